// File: rtl/pipe_stage_fifo_if.sv
// pipe_stage_fifo_if: handshake bundle between an upstream stage, the stage buffer and a downstream stage.
//
// Signals:
//   flush     - synchronous kill of buffered and incoming entries (branch/jump redirect)
//   in_valid  - upstream presents in_data
//   in_ready  - buffer can accept a payload this cycle
//   in_data   - upstream payload (packed stage struct)
//   out_valid - buffer presents out_data downstream
//   out_ready - downstream accepts out_data this cycle
//   out_data  - downstream payload, zero when out_valid is low
//   count     - number of entries held (0..DEPTH)
//
// Modports: master drives the upstream/downstream side, slave is the buffer.
interface pipe_stage_fifo_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic DEPTH-entry pipeline-stage buffer with valid/ready handshakes, flush and occupancy count.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - asynchronous active-high reset (count, pointers; storage is not reset)
//   bus   - pipe_stage_fifo_if.slave: flush, in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data, count
//
// Build option: define PIPE_STAGE_BYPASS_EN for zero-latency pass-through while
// empty; left undefined the buffer has a 1-cycle in-to-out latency and its
// outputs depend on registered state only.
module pipe_stage_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_fifo_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, push, pop, wr_en, rd_en;

    // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    // in_ready looks only at occupancy so it never waits on out_ready
    assign bus.in_ready = ~full;
    assign bus.count    = count_q;
    assign push         = bus.in_valid & ~full & ~bus.flush;
    assign pop          = bus.out_valid & bus.out_ready & ~bus.flush;

`ifdef PIPE_STAGE_BYPASS_EN
    logic through;
    assign bus.out_valid = ~empty | (bus.in_valid & ~bus.flush);
    assign bus.out_data  = ~empty ? mem_q[rd_ptr_q] : (bus.out_valid ? bus.in_data : '0);
    // empty with a push and a pop together: the payload went straight through
    assign through       = empty & push & pop;
    assign wr_en         = push & ~through;
    assign rd_en         = pop & ~through;
`else
    assign bus.out_valid = ~empty;
    assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign wr_en         = push;
    assign rd_en         = pop;
`endif

    always_comb begin
        wr_ptr_d = bus.flush ? '0 : (wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q);
        rd_ptr_d = bus.flush ? '0 : (rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q);
        count_d  = bus.flush ? '0
                 : (wr_en & ~rd_en) ? count_q + CNT_W'(1)
                 : (rd_en & ~wr_en) ? count_q - CNT_W'(1)
                 : count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage holds payload only; validity lives in count, so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= bus.in_data;
    end
endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: randomized and directed check of pipe_stage_fifo (DEPTH=2 and DEPTH=3) against a queue model.
module tb_pipe_stage_fifo;
    typedef logic [63:0] dq_t [$];

`ifdef PIPE_STAGE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        iv    = 1'b0;
    logic        fl    = 1'b0;
    logic        ordy  = 1'b0;
    logic [63:0] id    = '0;
    int          errors = 0;
    int          checks = 0;
    dq_t         q2, q3;

    pipe_stage_fifo_if #(.WIDTH(64), .DEPTH(2)) b2 ();
    pipe_stage_fifo_if #(.WIDTH(64), .DEPTH(3)) b3 ();

    assign b2.flush     = fl;
    assign b2.in_valid  = iv;
    assign b2.in_data   = id;
    assign b2.out_ready = ordy;
    assign b3.flush     = fl;
    assign b3.in_valid  = iv;
    assign b3.in_data   = id;
    assign b3.out_ready = ordy;

    pipe_stage_fifo #(.WIDTH(64), .DEPTH(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
    pipe_stage_fifo #(.WIDTH(64), .DEPTH(3)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_ov(dq_t q);
        return (q.size() != 0) || (BYP && iv && !fl);
    endfunction

    function automatic logic [63:0] exp_od(dq_t q);
        if (q.size() != 0) return q[0];
        return exp_ov(q) ? id : 64'h0;
    endfunction

    function automatic dq_t step(dq_t q, int d);
        logic push, pop;
        if (fl) begin
            q.delete();
            return q;
        end
        push = iv && (q.size() < d);
        pop  = exp_ov(q) && ordy;
        if (q.size() == 0 && push && pop) return q;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(id);
        return q;
    endfunction

    task automatic model_cmp();
        chk("in_ready2",  64'(b2.in_ready),  64'(q2.size() < 2));
        chk("out_valid2", 64'(b2.out_valid), 64'(exp_ov(q2)));
        chk("out_data2",  b2.out_data,       exp_od(q2));
        chk("count2",     64'(b2.count),     64'(q2.size()));
        chk("in_ready3",  64'(b3.in_ready),  64'(q3.size() < 3));
        chk("out_valid3", 64'(b3.out_valid), 64'(exp_ov(q3)));
        chk("out_data3",  b3.out_data,       exp_od(q3));
        chk("count3",     64'(b3.count),     64'(q3.size()));
    endtask

    task automatic finish_cyc();
        @(negedge clk);
        model_cmp();
        @(posedge clk);
        q2 = step(q2, 2);
        q3 = step(q3, 3);
        #1;
    endtask

    task automatic cyc(input logic v, input logic [63:0] d, input logic r, input logic f);
        iv = v; id = d; ordy = r; fl = f;
        finish_cyc();
    endtask

    initial begin
        int          cnt3_t [8] = '{1, 2, 3, 2, 3, 2, 1, 0};
        logic        v_t    [8] = '{1, 1, 1, 0, 1, 0, 0, 0};
        logic        r_t    [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
        logic [63:0] d_t    [8] = '{1, 2, 3, 0, 4, 0, 0, 0};
        logic [63:0] od3_t  [8] = '{1, 1, 1, 2, 2, 3, 4, 0};

        #1 reset = 1'b1;
        #2;
        chk("rst_count",     64'(b2.count),     64'd0);
        chk("rst_in_ready",  64'(b2.in_ready),  64'd1);
        chk("rst_out_valid", 64'(b2.out_valid), 64'd0);
        chk("rst_out_data",  b2.out_data,       64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        cyc(1'b1, 64'hA1, 1'b0, 1'b0);
        chk("fill1_count", 64'(b2.count), 64'd1);
        cyc(1'b1, 64'hB2, 1'b0, 1'b0);
        chk("fill2_count", 64'(b2.count), 64'd2);
        chk("full_in_ready", 64'(b2.in_ready), 64'd0);
        cyc(1'b1, 64'hC3, 1'b0, 1'b0);
        chk("full_ignore_count", 64'(b2.count), 64'd2);
        chk("head_A1", b2.out_data, 64'hA1);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("head_B2", b2.out_data, 64'hB2);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drained_valid", 64'(b2.out_valid), 64'd0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("drained3_count", 64'(b3.count), 64'd0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 64'h10 + 64'(i), 1'b1, 1'b0);
            chk("stream_count", 64'(b2.count), BYP ? 64'd0 : 64'd1);
            chk("stream_data", b2.out_data, 64'h10 + 64'(i));
        end
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            cyc(v_t[i], d_t[i], r_t[i], 1'b0);
            chk("wrap3_count", 64'(b3.count), 64'(cnt3_t[i]));
            chk("wrap3_data", b3.out_data, od3_t[i]);
        end
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);

        cyc(1'b1, 64'hE0, 1'b0, 1'b0);
        cyc(1'b1, 64'hE1, 1'b0, 1'b0);
        chk("preflush_count", 64'(b2.count), 64'd2);
        cyc(1'b1, 64'hEE, 1'b0, 1'b1);
        chk("flush_count2", 64'(b2.count), 64'd0);
        chk("flush_valid2", 64'(b2.out_valid), 64'd0);
        chk("flush_count3", 64'(b3.count), 64'd0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        chk("flush_no_EE", 64'(b2.out_valid), 64'd0);

        cyc(1'b1, 64'h31, 1'b0, 1'b0);
        cyc(1'b1, 64'h32, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        iv = 1'b0;
        #1;
        chk("async_rst_count",     64'(b2.count),     64'd0);
        chk("async_rst_out_valid", 64'(b2.out_valid), 64'd0);
        chk("async_rst_out_data",  b2.out_data,       64'd0);
        chk("async_rst_in_ready",  64'(b2.in_ready),  64'd1);
        chk("async_rst_count3",    64'(b3.count),     64'd0);
        q2.delete();
        q3.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        iv = 1'b1; id = 64'h55; ordy = 1'b1; fl = 1'b0;
        #1;
        chk("byp_same_valid", 64'(b2.out_valid), 64'(BYP));
        chk("byp_same_data", b2.out_data, BYP ? 64'h55 : 64'h0);
        finish_cyc();
        chk("byp_pass_count", 64'(b2.count), BYP ? 64'd0 : 64'd1);
        cyc(1'b1, 64'h55, 1'b0, 1'b0);
        chk("byp_hold_count", 64'(b2.count), BYP ? 64'd1 : 64'd2);
        chk("byp_hold_data", b2.out_data, 64'h55);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);
        cyc(1'b0, 64'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, {$urandom, $urandom},
                $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_fifo.md
Name: pipe_stage_fifo

Overview:
- Parametrised elastic pipeline-stage buffer placed between pipeline stages (fetch→decode, decode→execute, execute→memory, memory→writeback).
- Generalises the plain stage register into a DEPTH-entry FIFO of WIDTH-bit stage payloads (packed stage structs), with valid/ready handshakes on both sides.
- Supports a synchronous flush for branch/jump redirect.
- Provides an occupancy count for hazard logic.

Parameters:
- WIDTH, 64, payload width in bits (set to the width of the packed stage struct).
- DEPTH, 2, number of entries; legal range 1..16, need not be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered and incoming entries.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  buffer can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  buffer presents a payload downstream.
- out_ready  in  1  downstream accepts the payload this cycle.
- out_data  out  WIDTH  downstream payload; forced to 0 when out_valid=0.
- count  out  CNT_W  number of entries held (0..DEPTH).

Behaviour:
- Reset (async, any time, including mid-transfer):
  - count=0; write and read pointers = 0.
  - out_valid=0, out_data=0, in_ready=1.
  - Storage array is not reset.
- Handshakes:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - A transfer completes only on a cycle where valid and ready are both high.
  - Once out_valid=1 with no flush, out_valid and out_data stay stable until pop.
- in_ready = (count < DEPTH). It is registered-state only and never depends on out_ready or in_valid. When full, a same-cycle pop does not raise in_ready.
- Baseline output: out_valid = (count != 0); out_data = mem[rd_ptr] when out_valid, else 0. Latency in→out is 1 cycle.
- Pointers: write pointer advances on push, read pointer on pop. Each increments modulo DEPTH: from DEPTH-1 it wraps to 0 explicitly, not by bit overflow.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: unchanged, with both pointers advancing.
- Flush:
  - Highest priority below reset.
  - Next edge: count=0, both pointers=0.
  - The incoming in_data on that cycle is discarded and nothing pops.
  - Outputs follow registered state, so out_valid drops the cycle after flush.
- Boundaries:
  - Full (count==DEPTH): in_valid is ignored and in_data is not written.
  - Empty: out_valid=0 and out_data=0.
  - DEPTH=1 degenerates to a half-throughput register slice (no push while occupied). This is legal.
- There is no state machine beyond count and pointers; occupancy itself is the state. Empty/partial/full are derived from count.

Optional Feature:
- Macro PIPE_STAGE_BYPASS_EN.
- When defined (zero-latency bypass):
  - When count==0, in_valid=1 and flush=0: out_valid=1 and out_data=in_data combinationally in the same cycle.
  - If out_ready=1 too, the payload passes through without being written; count and pointers are unchanged.
  - If out_ready=0, the payload is written as a normal push.
  - out_valid = (count!=0) | (in_valid & ~flush).
- When undefined: baseline 1-cycle latency; out_valid and out_data depend on registered state only.

Test Plan:
- Reset then idle, WIDTH=64, DEPTH=2 -> count=0, in_ready=1, out_valid=0, out_data=0. Asserting reset mid-burst with count=2 clears all immediately, without waiting for a clock edge.
- Push 0xA1, 0xB2 with out_ready=0 -> count 1 then 2; in_ready=0 after second edge. A third push of 0xC3 is ignored. Raising out_ready yields 0xA1 then 0xB2, then out_valid=0.
- Continuous stream 0x10..0x1F with in_valid=out_ready=1, DEPTH=2 -> out_data 0x10..0x1F in order, each one cycle after push. count holds at 1 and pointers wrap repeatedly.
- DEPTH=3 wrap: push 1,2,3; pop 1; push 4; pop all -> order 1,2,3,4 with write pointer wrapping 2→0. count sequence 1,2,3,2,3,2,1,0.
- count=2 with flush=1 and in_valid=1 (data 0xEE) on the same cycle -> next cycle count=0, out_valid=0, and 0xEE is never output.
- PIPE_STAGE_BYPASS_EN defined, empty, in_valid=1, in_data=0x55, out_ready=1 -> out_valid=1 and out_data=0x55 in the same cycle; count stays 0. With out_ready=0 instead -> count=1 next cycle and 0x55 is held.
